// File: rtl/byte_striping_4l_pkg.sv
// Shared definitions for the 4-lane byte striper.
//   NUM_LANES        : number of output lanes
//   DEFAULT_PAD_BYTE : filler byte for unused lanes of a flushed partial word
//   state_t          : striper FSM encoding
//   partial_mask     : lane-valid mask for a partial word of 1..3 bytes
package byte_striping_4l_pkg;

  localparam int NUM_LANES = 4;
  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'hF7;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic logic [NUM_LANES-1:0] partial_mask(input logic [1:0] nbytes);
    case (nbytes)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/byte_striping_4l.sv
// Serial-to-4-lane byte striper. Bytes arriving one per clock (qualified by
// valid_in) are distributed round-robin over lanes 0..3. A completed word,
// or a PAD_BYTE-padded partial word when the stream pauses, is presented on
// registered lane outputs with a per-lane valid mask.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-low reset
//   data_in    in   [7:0] byte to stripe
//   valid_in   in   data_in qualifier
//   lane0..3   out  [7:0] lane bytes (lane0 = first byte of the word)
//   valid_out  out  [3:0] per-lane valid mask
//   flush_out  out  one-cycle pulse accompanying a padded partial word
//   word_cnt   out  [CNT_W-1:0] emitted words, saturating
//
// States:
//   IDLE | lane pointer 0, nothing buffered
//   FILL | 1..3 bytes buffered, pointer = number of buffered bytes
module byte_striping_4l
  import byte_striping_4l_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = DEFAULT_PAD_BYTE,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic [7:0]       lane0_out,
  output logic [7:0]       lane1_out,
  output logic [7:0]       lane2_out,
  output logic [7:0]       lane3_out,
  output logic [3:0]       valid_out,
  output logic             flush_out,
  output logic [CNT_W-1:0] word_cnt
);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [7:0]       r_buf  [0:2];
  logic [7:0]       r_lane [0:NUM_LANES-1];
  logic [3:0]       r_valid;
  logic             r_flush;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [7:0]       w_buf_nxt  [0:2];
  logic [7:0]       w_lane_nxt [0:NUM_LANES-1];
  logic [3:0]       w_valid_nxt;
  logic             w_flush_nxt;
  logic             w_emit;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_buf_nxt   = r_buf;
    w_lane_nxt  = r_lane;   // lanes hold while valid_out is low
    w_valid_nxt = 4'b0000;
    w_flush_nxt = 1'b0;
    w_emit      = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_buf_nxt[0] = data_in;
          w_ptr_nxt    = 2'd1;
          w_state_nxt  = FILL;
        end
      end

      FILL: begin
        if (valid_in) begin
          if (r_ptr == 2'd3) begin
            // Fourth byte goes straight to lane 3, never through a buffer.
            w_lane_nxt[0] = r_buf[0];
            w_lane_nxt[1] = r_buf[1];
            w_lane_nxt[2] = r_buf[2];
            w_lane_nxt[3] = data_in;
            w_valid_nxt   = 4'b1111;
            w_ptr_nxt     = 2'd0;
            w_state_nxt   = IDLE;
            w_emit        = 1'b1;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (r_ptr == 2'(i)) w_buf_nxt[i] = data_in;
            end
            w_ptr_nxt = r_ptr + 2'd1;
          end
        end else begin
          // Stream paused: emit what is buffered, pad the rest.
          for (int i = 0; i < 3; i++) begin
            w_lane_nxt[i] = (2'(i) < r_ptr) ? r_buf[i] : PAD_BYTE;
          end
          w_lane_nxt[3] = PAD_BYTE;
          w_valid_nxt   = partial_mask(r_ptr);
          w_flush_nxt   = 1'b1;
          w_ptr_nxt     = 2'd0;
          w_state_nxt   = IDLE;
          w_emit        = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = 2'd0;
      end
    endcase
  end

  assign w_cnt_nxt = (w_emit && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_valid <= 4'b0000;
      r_flush <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < 3; i++)         r_buf[i]  <= 8'h00;
      for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_valid_nxt;
      r_flush <= w_flush_nxt;
      r_cnt   <= w_cnt_nxt;
      for (int i = 0; i < 3; i++)         r_buf[i]  <= w_buf_nxt[i];
      for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= w_lane_nxt[i];
    end
  end

  assign lane0_out = r_lane[0];
  assign lane1_out = r_lane[1];
  assign lane2_out = r_lane[2];
  assign lane3_out = r_lane[3];
  assign valid_out = r_valid;
  assign flush_out = r_flush;
  assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_byte_striping_4l.sv
module tb_byte_striping_4l;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;

  logic [7:0]  l0, l1, l2, l3;
  logic [3:0]  vo;
  logic        fo;
  logic [15:0] cnt;

  logic [7:0]  s0, s1, s2, s3;
  logic [3:0]  svo;
  logic        sfo;
  logic [1:0]  scnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  logic [31:0] exp_lanes;
  logic [3:0]  exp_valid;
  logic        exp_flush;
  int          exp_cnt;

  always #5 clk = ~clk;

  byte_striping_4l dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane0_out(l0), .lane1_out(l1), .lane2_out(l2), .lane3_out(l3),
    .valid_out(vo), .flush_out(fo), .word_cnt(cnt)
  );

  byte_striping_4l #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane0_out(s0), .lane1_out(s1), .lane2_out(s2), .lane3_out(s3),
    .valid_out(svo), .flush_out(sfo), .word_cnt(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: bytes collect in a queue; 4 bytes make a full word, a gap
  // with bytes pending makes a padded partial word.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rst_n = 1'b1);
    reset    = rst_n;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      exp_lanes = 32'h0;
      exp_valid = 4'b0000;
      exp_flush = 1'b0;
      exp_cnt   = 0;
    end else if (v) begin
      q.push_back(d);
      exp_flush = 1'b0;
      if (q.size() == 4) begin
        exp_lanes = {q[0], q[1], q[2], q[3]};
        exp_valid = 4'b1111;
        exp_cnt++;
        q.delete();
      end else begin
        exp_valid = 4'b0000;
      end
    end else if (q.size() > 0) begin
      exp_lanes = {4{8'hF7}};
      for (int i = 0; i < q.size(); i++) exp_lanes[31-8*i -: 8] = q[i];
      exp_valid = 4'((1 << q.size()) - 1);
      exp_flush = 1'b1;
      exp_cnt++;
      q.delete();
    end else begin
      exp_valid = 4'b0000;
      exp_flush = 1'b0;
    end
    chk("lanes", {l0, l1, l2, l3}, exp_lanes);
    chk("valid_out", 32'(vo), 32'(exp_valid));
    chk("flush_out", 32'(fo), 32'(exp_flush));
    chk("word_cnt", 32'(cnt), 32'(exp_cnt));
    chk("sat_lanes", {s0, s1, s2, s3}, exp_lanes);
    chk("sat_word_cnt", 32'(scnt), 32'((exp_cnt > 3) ? 3 : exp_cnt));
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    exp_lanes = 32'h0;
    exp_valid = 4'b0;
    exp_flush = 1'b0;
    exp_cnt   = 0;

    cycle(0, 8'h00, 0);
    cycle(1, 8'h5A, 0);

    // single full word
    cycle(1, 8'h11); cycle(1, 8'h22); cycle(1, 8'h33); cycle(1, 8'h44);
    chk("word1_mask", 32'(vo), 32'hF);
    cycle(0, 8'h00);

    // continuous stream of three words
    for (int i = 0; i < 12; i++) cycle(1, 8'(i));
    chk("stream_cnt", 32'(cnt), 32'd4);
    cycle(0, 8'h00);

    // two-byte partial word, flush pulse must drop next cycle
    cycle(1, 8'hA1); cycle(1, 8'hA2);
    cycle(0, 8'h00);
    chk("flush2_lanes", {l0, l1, l2, l3}, 32'hA1A2F7F7);
    chk("flush2_mask", 32'(vo), 32'h3);
    cycle(0, 8'h00);
    chk("flush_pulse_end", 32'(fo), 32'h0);

    // three bytes, gap, four bytes
    cycle(1, 8'hB1); cycle(1, 8'hB2); cycle(1, 8'hB3);
    cycle(0, 8'h00);
    chk("flush3_mask", 32'(vo), 32'h7);
    cycle(1, 8'hC1); cycle(1, 8'hC2); cycle(1, 8'hC3); cycle(1, 8'hC4);
    chk("after_flush_word", {l0, l1, l2, l3}, 32'hC1C2C3C4);
    cycle(1, 8'hD1); cycle(0, 8'h00);
    chk("one_byte_flush", {l0, l1, l2, l3}, 32'hD1F7F7F7);

    // reset mid-word discards buffered bytes
    cycle(1, 8'hE1); cycle(1, 8'hE2);
    cycle(1, 8'hEE, 0);
    chk("rst_lanes", {l0, l1, l2, l3}, 32'h0);
    cycle(0, 8'h00, 0);
    cycle(1, 8'hF1); cycle(1, 8'hF2); cycle(1, 8'hF3); cycle(1, 8'hF4);
    chk("post_rst_word", {l0, l1, l2, l3}, 32'hF1F2F3F4);
    chk("post_rst_cnt", 32'(cnt), 32'd1);

    // five words into the 2-bit counter: 1,2,3,3,3
    cycle(0, 8'h00, 0);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) cycle(1, 8'(16 * w + b));
      chk("sat_seq", 32'(scnt), 32'((w + 1 > 3) ? 3 : w + 1));
    end

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 63) != 0);
    end
    cycle(0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_striping_4l.md
# byte_striping_4l

Serial-to-4-lane byte striper for the PCIe physical layer transmit path. It accepts one byte per clock with a valid qualifier and distributes consecutive bytes round-robin across lanes 0..3. It presents a completed 4-byte word, or a padded partial word when the stream pauses, as registered lane outputs with a per-lane valid mask. Its outputs feed the 4-in/4-out lane register stage directly.

## Interface
Parameters:
- PAD_BYTE, default 8'hF7: byte placed on unused lanes of a flushed partial word.
- CNT_W, default 16: width of the completed-word counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; clock clk.
- data_in  in  8  byte to stripe.
- valid_in  in  1  data_in qualifier; one byte consumed per cycle when high.
- lane0_out  out  8  stripe byte 0 (first byte of word).
- lane1_out  out  8  stripe byte 1.
- lane2_out  out  8  stripe byte 2.
- lane3_out  out  8  stripe byte 3 (last byte of word).
- valid_out  out  4  per-lane valid mask; bit i qualifies lane i.
- flush_out  out  1  one-cycle pulse, high with a partial (padded) word.
- word_cnt  out  CNT_W  count of emitted words (full and partial); saturates at all-ones.

## Operation
- FSM states:
  - IDLE: lane pointer is 0, no bytes buffered.
  - FILL: 1..3 bytes are buffered.
- Lane pointer ptr is 2 bits. Shadow buffers buf0..buf2 are 8 bits each.
- IDLE, valid_in=1: buf0<=data_in, ptr<=1, go to FILL. valid_out<=0.
- IDLE, valid_in=0: stay. valid_out<=0, flush_out<=0.
- FILL, valid_in=1, ptr<3: buf[ptr]<=data_in, ptr<=ptr+1. valid_out<=0.
- FILL, valid_in=1, ptr==3 (full word):
  - lane0..3 <= {buf0, buf1, buf2, data_in}; valid_out<=4'b1111.
  - ptr<=0, go to IDLE, word_cnt increments.
- FILL, valid_in=0 (flush):
  - Lanes i<ptr get buf[i]; lanes i>=ptr get PAD_BYTE.
  - valid_out<=(1<<ptr)-1, i.e. 4'b0001, 4'b0011 or 4'b0111.
  - flush_out<=1, ptr<=0, go to IDLE, word_cnt increments.
- Lane data outputs hold their last value while valid_out==0. Downstream must qualify data with valid_out only.
- No backpressure: the block can accept a byte every cycle, and every byte emerges in exactly one word.
- word_cnt saturates at 2^CNT_W-1 and does not wrap.

## Timing
- All outputs are registered.
- A full word is visible on the outputs after the edge that samples its 4th byte. Latency from 4th byte to output is 1 cycle; from 1st byte it is 4 cycles.
- A partial word is visible after the first edge that samples valid_in=0 while in FILL.
- Back-to-back words: a continuous valid stream produces valid_out=4'b1111 every 4th cycle and 0 in between.
- A new byte in the cycle after a flush starts a fresh word at lane 0. No byte is lost.
- Reset (reset==0 at posedge) has priority over all other inputs:
  - lane0..3_out=0, valid_out=0, flush_out=0, word_cnt=0, ptr=0, buffers=0, state=IDLE.
- Reset mid-word discards the buffered bytes. No partial word is emitted.

## Structure
- The shared package holds:
  - NUM_LANES=4
  - default PAD_BYTE 8'hF7
  - state encoding IDLE=1'b0, FILL=1'b1
- Single flat module; no sub-module is warranted. The saturating counter stays inline.

## Test plan
- Reset, then 4 bytes 8'h11, 22, 33, 44 on consecutive cycles -> one cycle after 44 is sampled: lanes 11/22/33/44, valid_out=4'b1111, flush_out=0, word_cnt=1.
- Continuous stream 8'h00..8'h0B over 12 cycles -> three words {00,01,02,03}, {04..07}, {08..0B}, spaced 4 cycles apart, word_cnt=3.
- Bytes A1, A2 then valid_in=0 -> lanes A1/A2/F7/F7, valid_out=4'b0011, flush_out=1 for exactly one cycle.
- 3 bytes, one idle cycle, then 4 bytes -> partial word with mask 4'b0111, followed 4 cycles later by a full word that starts on lane 0.
- reset asserted after 2 of 4 bytes, then released and 4 new bytes sent -> all outputs 0 during reset, no partial word, next word contains only the new bytes.
- CNT_W=2 with 5 words -> word_cnt sequence 1, 2, 3, 3, 3 (saturates).
